// File: rtl/nibble_serial_add_ctrl.sv
// Serial WIDTH-bit adder sequencer driving one external 4-bit full-adder slice, LSB nibble first.
// Optional SUBTRACT_EN adds a sub_i input that turns the operation into op_a - op_b.
module nibble_serial_add_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] op_a_i,
   input  logic [WIDTH-1:0] op_b_i,
   input  logic             cin_i,
`ifdef SUBTRACT_EN
   input  logic             sub_i,
`endif
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             cout_o,
   output logic [3:0]       add_a_o,
   output logic [3:0]       add_b_o,
   output logic             add_cin_o,
   input  logic [3:0]       add_sum_i,
   input  logic             add_cout_i
);

   localparam int unsigned NIB = WIDTH / 4;
   localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [IW-1:0]    idx_q;
   logic [WIDTH-1:0] result_q;
   logic             cout_q;

   logic [WIDTH-1:0] b_load;
   logic             c_load;
   logic [IW+1:0]    bit_pos;

   // Subtraction is a + ~b + 1, so only the latched B and the initial carry change.
   always_comb begin
`ifdef SUBTRACT_EN
      b_load = sub_i ? ~op_b_i : op_b_i;
      c_load = sub_i ? 1'b1 : cin_i;
`else
      b_load = op_b_i;
      c_load = cin_i;
`endif
   end

   assign bit_pos = {idx_q, 2'b00};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (start_i) begin
                  a_q     <= op_a_i;
                  b_q     <= b_load;
                  carry_q <= c_load;
                  idx_q   <= '0;
                  state_q <= StRun;
               end else begin
                  state_q <= StIdle;
               end
            end
            StRun: begin
               result_q[bit_pos +: 4] <= add_sum_i;
               carry_q                <= add_cout_i;
               if (idx_q == IW'(NIB - 1)) begin
                  cout_q  <= add_cout_i;
                  idx_q   <= '0;
                  state_q <= StDone;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy_o    = (state_q == StRun);
   assign done_o    = (state_q == StDone);
   assign result_o  = result_q;
   assign cout_o    = cout_q;
   assign add_a_o   = busy_o ? a_q[bit_pos +: 4] : 4'h0;
   assign add_b_o   = busy_o ? b_q[bit_pos +: 4] : 4'h0;
   assign add_cin_o = busy_o ? carry_q : 1'b0;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (WIDTH=16) with a behavioural 4-bit adder slice.
// Define SUBTRACT_EN to also exercise the subtract option.
module tb_nibble_serial_add_ctrl;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned NIB   = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             cin;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic [3:0]       add_a;
   logic [3:0]       add_b;
   logic             add_cin;
   logic [3:0]       add_sum;
   logic             add_cout;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [WIDTH:0] sb_q[$];

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             c;
      logic [WIDTH-1:0] exp_r;
      logic             exp_c;
   } vec_t;

   vec_t vecs[6];

   always #5 clk = ~clk;

   assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

   nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .op_a_i     (op_a),
      .op_b_i     (op_b),
      .cin_i      (cin),
`ifdef SUBTRACT_EN
      .sub_i      (sub),
`endif
      .busy_o     (busy),
      .done_o     (done),
      .result_o   (result),
      .cout_o     (cout),
      .add_a_o    (add_a),
      .add_b_o    (add_b),
      .add_cin_o  (add_cin),
      .add_sum_i  (add_sum),
      .add_cout_i (add_cout)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("done_unexpected", 32'd1, 32'd0);
         end else begin
            logic [WIDTH:0] e;
            e = sb_q.pop_front();
            chk("result", 32'(result), 32'(e[WIDTH-1:0]));
            chk("cout", 32'(cout), 32'(e[WIDTH]));
         end
      end
   end

   task automatic wait_done(output int nbusy);
      bit seen = 1'b0;
      nbusy = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
         else if (busy === 1'b1) nbusy++;
      end
      chk("done_seen", 32'(seen), 32'd1);
   endtask

   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                         input logic s, input logic [WIDTH-1:0] er, input logic ec);
      int n;
      logic [WIDTH-1:0] b_eff;
      logic             c_eff;
      b_eff = s ? ~b : b;
      c_eff = s ? 1'b1 : c;
      @(posedge clk); #1;
      op_a = a; op_b = b; cin = c; sub = s; start = 1'b1;
      sb_q.push_back({ec, er});
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("run1_busy", 32'(busy), 32'd1);
      chk("run1_add_a", 32'(add_a), 32'(a[3:0]));
      chk("run1_add_b", 32'(add_b), 32'(b_eff[3:0]));
      chk("run1_add_cin", 32'(add_cin), 32'(c_eff));
      // Operands are already captured; these must not reach the result.
      op_a = WIDTH'($urandom); op_b = WIDTH'($urandom); cin = ~cin; sub = ~sub;
      wait_done(n);
      chk("busy_cycles", 32'(n + 1), 32'(NIB));
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("idle_add_a", 32'(add_a), 32'd0);
   endtask

   initial begin
      int n;
      bit any_done;
      logic [WIDTH-1:0] ra, rb;
      logic             rc;
      logic [WIDTH:0]   rsum;

      vecs[0] = '{16'h0006, 16'h0004, 1'b0, 16'h000A, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
      vecs[3] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
      vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
      vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};

      rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_add_a", 32'(add_a), 32'd0);
      chk("rst_add_b", 32'(add_b), 32'd0);
      chk("rst_add_cin", 32'(add_cin), 32'd0);

      foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, vecs[i].exp_r, vecs[i].exp_c);

      for (int i = 0; i < 4; i++) begin
         ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
         rsum = (WIDTH + 1)'(ra) + (WIDTH + 1)'(rb) + (WIDTH + 1)'(rc);
         run_op(ra, rb, rc, 1'b0, rsum[WIDTH-1:0], rsum[WIDTH]);
      end

      // Back-to-back: second start lands in the DONE cycle.
      @(posedge clk); #1;
      op_a = 16'h1234; op_b = 16'h8765; cin = 1'b1; start = 1'b1;
      sb_q.push_back({1'b0, 16'h999A});
      @(posedge clk); #1 start = 1'b0;
      wait_done(n);
      op_a = 16'h0001; op_b = 16'h0001; cin = 1'b0; start = 1'b1;
      sb_q.push_back({1'b0, 16'h0002});
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("b2b_no_gap", 32'(busy), 32'd1);
      wait_done(n);
      chk("b2b_busy_cycles", 32'(n + 1), 32'(NIB));

      // Start pulsed mid-RUN must be ignored.
      @(posedge clk); #1;
      op_a = 16'h00FF; op_b = 16'h0001; cin = 1'b0; start = 1'b1;
      sb_q.push_back({1'b0, 16'h0100});
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1 op_a = 16'h1111; op_b = 16'h1111; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(n);
      @(negedge clk);
      chk("ign_no_second_done", 32'(done), 32'd0);
      chk("ign_idle", 32'(busy), 32'd0);

      // Reset during the second RUN cycle aborts without a done pulse.
      @(posedge clk); #1;
      op_a = 16'hFFFF; op_b = 16'hFFFF; cin = 1'b1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_result", 32'(result), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      chk("abort_add_a", 32'(add_a), 32'd0);
      chk("abort_add_b", 32'(add_b), 32'd0);
      chk("abort_add_cin", 32'(add_cin), 32'd0);
      any_done = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done === 1'b1) any_done = 1'b1;
      end
      chk("abort_no_done", 32'(any_done), 32'd0);

`ifdef SUBTRACT_EN
      run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
      run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
      run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
      run_op(16'h0007, 16'h0005, 1'b1, 1'b0, 16'h000D, 1'b0);
`endif

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
